// File: rtl/muldiv_unit.sv
// Multi-cycle integer multiply/divide unit owning the HI/LO pair.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle, with a sign-fix cycle.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             abort,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned W2    = 2 * WIDTH;

    localparam logic [2:0] OpMultu = 3'b000;
    localparam logic [2:0] OpMult  = 3'b001;
    localparam logic [2:0] OpDivu  = 3'b010;
    localparam logic [2:0] OpDiv   = 3'b011;
    localparam logic [2:0] OpMthi  = 3'b100;
    localparam logic [2:0] OpMtlo  = 3'b101;

    typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [W2-1:0]      acc_q, acc_d;     // mult: {partial, multiplier}; div: quotient in low half
    logic [WIDTH:0]     rem_q, rem_d;
    logic [WIDTH-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
    logic               is_div_q, is_div_d;
    logic               sgn_q, sgn_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               div0_q, div0_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] x);
        return ~x + WIDTH'(1);
    endfunction

    function automatic logic [W2-1:0] neg_w2(input logic [W2-1:0] x);
        return ~x + W2'(1);
    endfunction

    logic             op_signed;
    logic [WIDTH-1:0] abs_a, abs_b;
    assign op_signed = op[0];
    assign abs_a = (op_signed && a[WIDTH-1]) ? neg_w(a) : a;
    assign abs_b = (op_signed && b[WIDTH-1]) ? neg_w(b) : b;

    // One multiply step: conditionally add multiplicand to the upper half, then shift right.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc_q[W2-1:WIDTH]} + (acc_q[0] ? {1'b0, opb_q} : '0);

    // One restoring divide step; the trial is one bit wider so its MSB is the borrow.
    logic [WIDTH+1:0] div_shift, div_trial;
    assign div_shift = {rem_q, acc_q[WIDTH-1]};
    assign div_trial = div_shift - {2'b00, opb_q};

    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quo_fix, rem_fix;
    assign prod_fix = neg_lo_q ? neg_w2(acc_q) : acc_q;
    assign quo_fix  = (div0_q && sgn_q) ? '1
                    : (neg_lo_q ? neg_w(acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0]);
    assign rem_fix  = neg_hi_q ? neg_w(rem_q[WIDTH-1:0]) : rem_q[WIDTH-1:0];

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        rem_d    = rem_q;
        opb_d    = opb_q;
        is_div_d = is_div_q;
        sgn_d    = sgn_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        div0_d   = div0_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    case (op)
                        OpMultu, OpMult, OpDivu, OpDiv: begin
                            state_d  = StRun;
                            cnt_d    = '0;
                            is_div_d = op[1];
                            sgn_d    = op_signed;
                            neg_lo_d = op_signed && (a[WIDTH-1] ^ b[WIDTH-1]);
                            neg_hi_d = op[1] ? (op_signed && a[WIDTH-1])
                                             : (op_signed && (a[WIDTH-1] ^ b[WIDTH-1]));
                            div0_d   = (b == '0);
                            acc_d    = {{WIDTH{1'b0}}, abs_a};
                            rem_d    = '0;
                            opb_d    = abs_b;
                        end
                        OpMthi: begin
                            hi_d   = a;
                            done_d = 1'b1;
                        end
                        OpMtlo: begin
                            lo_d   = a;
                            done_d = 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
            StRun: begin
                if (abort) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    if (is_div_q) begin
                        if (!div_trial[WIDTH+1]) begin
                            rem_d = div_trial[WIDTH:0];
                            acc_d = {acc_q[W2-1:WIDTH], acc_q[WIDTH-2:0], 1'b1};
                        end else begin
                            rem_d = div_shift[WIDTH:0];
                            acc_d = {acc_q[W2-1:WIDTH], acc_q[WIDTH-2:0], 1'b0};
                        end
                    end else begin
                        acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == CNT_W'(WIDTH - 1)) begin
                        state_d = StFix;
                    end
                end
            end
            StFix: begin
                state_d = StIdle;
                cnt_d   = '0;
                if (!abort) begin
                    if (is_div_q) begin
                        hi_d = rem_fix;
                        lo_d = quo_fix;
                    end else begin
                        hi_d = prod_fix[W2-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                    done_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            rem_q    <= '0;
            opb_q    <= '0;
            is_div_q <= 1'b0;
            sgn_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            div0_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            rem_q    <= rem_d;
            opb_q    <= opb_d;
            is_div_q <= is_div_d;
            sgn_q    <= sgn_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            div0_q   <= div0_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != StIdle);
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
